// File: rtl/stkr_pkg.sv
// stkr_pkg: shared states, drive codes and default timing for the stacker speed path
package stkr_pkg;

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_LOW, S_HIGH, S_BRAKE, S_FAULT} state_t;

  localparam logic [3:0] DRV_STOP = 4'b1101;
  localparam logic [3:0] DRV_LOW  = 4'b0111;
  localparam logic [3:0] DRV_HIGH = 4'b1011;
  localparam logic [3:0] DRV_NONE = 4'b1111;

  localparam int unsigned DEF_START_DLY  = 64;
  localparam int unsigned DEF_GAP        = 2;
  localparam int unsigned DEF_SPINUP_MAX = 4096;
  localparam int unsigned DEF_COAST      = 256;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    m = (d > m) ? d : m;
    return m;
  endfunction

endpackage

// File: rtl/stkr_drive.sv
// stkr_drive: pairs the sequencer with the rate limiter it drives
module stkr_drive
  import stkr_pkg::*;
#(
  parameter int unsigned START_DLY  = DEF_START_DLY,
  parameter int unsigned GAP        = DEF_GAP,
  parameter int unsigned SPINUP_MAX = DEF_SPINUP_MAX,
  parameter int unsigned COAST      = DEF_COAST
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_ready,
  output logic o_busy,
  output logic o_fault
);

  logic ls1, ls2, hs, stopped, atspeed;

  stkr_seq #(
    .START_DLY (START_DLY),
    .GAP       (GAP),
    .SPINUP_MAX(SPINUP_MAX),
    .COAST     (COAST)
  ) u_seq (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_run    (i_run),
    .i_atspeed(atspeed),
    .o_ls1    (ls1),
    .o_ls2    (ls2),
    .o_hs     (hs),
    .o_stopped(stopped),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_fault  (o_fault)
  );

  stkr_rate u_rate (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_ls1    (ls1),
    .i_ls2    (ls2),
    .i_hs     (hs),
    .i_stopped(stopped),
    .o_atspeed(atspeed)
  );

endmodule

// File: rtl/stkr_rate.sv
// stkr_rate: stacker rate limiter; charge ramps toward the selected speed level
module stkr_rate #(
  parameter int unsigned W      = 8,
  parameter int unsigned LOW_LV = 64,
  parameter int unsigned THRESH = 200
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ls1,
  input  logic i_ls2,
  input  logic i_hs,
  input  logic i_stopped,
  output logic o_atspeed
);

  logic [W-1:0] charge_q, charge_d;
  logic         at_q, low;

  assign low = !i_ls1 && !i_ls2;

  // High speed charges to full, low speed settles at LOW_LV, stop discharges, no drive holds.
  always_comb begin
    charge_d = (!i_hs && charge_q != '1)               ? charge_q + 1'b1 :
               (low && charge_q < W'(LOW_LV))          ? charge_q + 1'b1 :
               (low && charge_q > W'(LOW_LV))          ? charge_q - 1'b1 :
               (!i_stopped && !low && charge_q != '0)  ? charge_q - 1'b1 : charge_q;
  end

  // Charge register and at-speed comparator.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      charge_q <= '0;
      at_q     <= 1'b0;
    end else begin
      charge_q <= charge_d;
      at_q     <= (charge_d >= W'(THRESH));
    end
  end

  assign o_atspeed = at_q;

endmodule

// File: rtl/stkr_seq.sv
// stkr_seq: break-before-make stacker drive sequencer with spin-up supervision
module stkr_seq
  import stkr_pkg::*;
#(
  parameter int unsigned START_DLY  = DEF_START_DLY,
  parameter int unsigned GAP        = DEF_GAP,
  parameter int unsigned SPINUP_MAX = DEF_SPINUP_MAX,
  parameter int unsigned COAST      = DEF_COAST
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_atspeed,
  output logic o_ls1,
  output logic o_ls2,
  output logic o_hs,
  output logic o_stopped,
  output logic o_ready,
  output logic o_busy,
  output logic o_fault
);

  localparam int unsigned CW = $clog2(max4(START_DLY, GAP, SPINUP_MAX, COAST) + 1);
  // Timers hold N-1 so that the N-th counted cycle is the one that sees zero.
  localparam logic [CW-1:0] L_START = CW'(START_DLY - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(GAP - 1);
  localparam logic [CW-1:0] L_SPIN  = CW'(SPINUP_MAX - 1);
  localparam logic [CW-1:0] L_COAST = CW'(COAST - 1);

  state_t        state_q, state_d, tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    drv_q, drv_d;
  logic          seen_q, ready_q, busy_q, fault_q;
  logic          cnt_z;

  assign cnt_z = (cnt_q == '0);

  // Next state, pending target and shared down-counter.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_z ? cnt_q : cnt_q - 1'b1;
    case (state_q)
      S_IDLE: if (i_run) begin
        state_d = S_GAP;
        tgt_d   = S_LOW;
        cnt_d   = L_GAP;
      end
      S_GAP: begin
        if (!i_run && tgt_q != S_BRAKE) tgt_d = S_BRAKE;
        if (cnt_z) begin
          state_d = tgt_d;
          cnt_d   = (tgt_d == S_LOW) ? L_START : (tgt_d == S_HIGH) ? L_SPIN : L_COAST;
        end
      end
      S_LOW: if (!i_run || cnt_z) begin
        state_d = S_GAP;
        tgt_d   = i_run ? S_HIGH : S_BRAKE;
        cnt_d   = L_GAP;
      end
      S_HIGH: if (!i_run) begin
        state_d = S_GAP;
        tgt_d   = S_BRAKE;
        cnt_d   = L_GAP;
      end else if (i_atspeed) cnt_d = L_SPIN;
      else if (cnt_z) state_d = S_FAULT;
      S_BRAKE: if (i_atspeed) cnt_d = L_COAST;
      else if (cnt_z) state_d = S_IDLE;
      default: ;
    endcase
  end

  // Drive code decoded from the next state so outputs change on the transition edge.
  always_comb begin
    drv_d = (state_d == S_LOW)  ? DRV_LOW[3:1]  :
            (state_d == S_HIGH) ? DRV_HIGH[3:1] :
            (state_d == S_GAP)  ? DRV_NONE[3:1] : DRV_STOP[3:1];
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      tgt_q   <= S_IDLE;
      cnt_q   <= '0;
      drv_q   <= DRV_STOP[3:1];
      seen_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      seen_q  <= (state_q == S_HIGH) && i_atspeed;
      ready_q <= (state_d == S_HIGH) && seen_q;
      busy_q  <= (state_d != S_IDLE);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign o_ls1     = drv_q[2];
  assign o_ls2     = drv_q[2];
  assign o_hs      = drv_q[1];
  assign o_stopped = drv_q[0];
  assign o_ready   = ready_q;
  assign o_busy    = busy_q;
  assign o_fault   = fault_q;

endmodule

// File: doc/stkr_seq.md
# stkr_seq

Stacker drive sequencer for the stacker speed path. It turns a single run request into the active-low speed-select levels (`o_ls1`, `o_ls2`, `o_hs`, `o_stopped`) consumed by the stacker rate limiter, and watches that limiter's at-speed output. Transitions are break-before-make, spin-up is supervised with a timeout, and a ready/fault status goes back to the control-unit sequencing logic.

## Interface
- `START_DLY`, 64: cycles held in low speed before the high-speed request.
- `GAP`, 2: cycles with all drives released between any two different drive selections.
- `SPINUP_MAX`, 4096: cycles allowed in HIGH without `i_atspeed` before a fault.
- `COAST`, 256: cycles `i_atspeed` must stay low in BRAKE before returning to IDLE.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset, synchronous, active-high; clock `i_clk`.
- `i_run`  in  1  level; 1 = stacker requested running.
- `i_atspeed`  in  1  rate-limiter output; 1 = charge at or above threshold.
- `o_ls1`, `o_ls2`  out  1 each  active-low low-speed select; both are always driven equal.
- `o_hs`  out  1  active-low high-speed select.
- `o_stopped`  out  1  active-low stop/brake select.
- `o_ready`  out  1  at speed in HIGH.
- `o_busy`  out  1  state is not IDLE.
- `o_fault`  out  1  sticky spin-up/speed-loss fault.

## Operation
- States: IDLE, GAP, LOW, HIGH, BRAKE, FAULT. All outputs are registered, decoded from the next state.
- Drive codes, active-low:
  - IDLE, BRAKE, FAULT: `o_stopped`=0; others 1.
  - LOW: `o_ls1`=`o_ls2`=0; others 1.
  - HIGH: `o_hs`=0; others 1.
  - GAP: all four 1 (no drive; the limiter holds its charge).
- IDLE: `i_run`=1 → GAP with pending target LOW.
- GAP: counts `GAP` cycles, then enters the pending target and loads that target's timer.
  - If `i_run`=0 while the target is LOW or HIGH, the target becomes BRAKE. The gap count does not restart.
- LOW: counts `START_DLY` cycles, then → GAP with target HIGH. `i_run`=0 → GAP with target BRAKE.
- HIGH:
  - The spin-up timer loads `SPINUP_MAX` on entry and reloads whenever `i_atspeed`=1.
  - It decrements while `i_atspeed`=0. If it expires → FAULT.
  - `o_ready`=1 only in HIGH with `i_atspeed`=1, registered one cycle late.
  - Speed loss (`i_atspeed` 1→0) drops `o_ready` and starts a fresh `SPINUP_MAX` window.
  - `i_run`=0 → GAP with target BRAKE; this takes priority over timeout on the same cycle.
- BRAKE: the coast timer loads `COAST` and reloads whenever `i_atspeed`=1. When it expires → IDLE with no gap, since the drive code is the same. `i_run` is ignored until IDLE.
- FAULT: `o_fault`=1. Exit only by `i_reset`.
- One shared down-counter of width `$clog2(max(START_DLY, GAP, SPINUP_MAX, COAST)+1)`. Unsigned; no wrap, because every state reloads the counter before use.

## Timing
- Reset values: state IDLE; `o_stopped`=0; `o_ls1`=`o_ls2`=`o_hs`=1; `o_ready`=`o_busy`=`o_fault`=0.
- Reset asserted in any state forces the values above on the next edge, including mid-GAP and in FAULT.
- Timeline from `i_run`=1 sampled at edge 0 in IDLE:
  - Drives released after edge 0.
  - LOW code visible after edge `GAP`.
  - HIGH code visible after edge `GAP+START_DLY+GAP`.
- `o_ready` rises on the edge after the first edge that samples `i_atspeed`=1 in HIGH.
- `i_run`=0 in HIGH: drives released on the next edge; brake code visible `GAP` edges later.
- Fault: FAULT is entered on the edge where the spin-up counter would pass zero, i.e. `SPINUP_MAX` sampled-low cycles in HIGH. `o_fault` is visible after that edge.

## Structure
- Shared package `stkr_pkg`:
  - state enum;
  - 4-bit drive-code constants `DRV_STOP`, `DRV_LOW`, `DRV_HIGH`, `DRV_NONE`, ordered {ls, hs, stop, spare};
  - default timing constants.
- No sub-module is needed; the counter is inline.
- A top-level pairing wrapper `stkr_drive` instantiates `stkr_seq` and the rate limiter, with `o_ls1`/`o_ls2`/`o_hs`/`o_stopped` feeding the limiter inputs and its output feeding back as `i_atspeed`.

## Test plan
Bench parameters: `START_DLY`=8, `GAP`=2, `SPINUP_MAX`=100, `COAST`=16.
- Reset, then idle 10 cycles → `o_stopped`=0, all other drives 1, status outputs 0.
- `i_run`↑ at edge 0 → drives all 1 at edges 1–2; LOW at edges 3–10; release at edges 11–12; HIGH from edge 13. Set `i_atspeed`=1 at edge 20 → `o_ready`=1 after edge 21.
- HIGH with `i_atspeed` held 0 → FAULT after exactly 100 cycles. `o_fault` stays 1 with `i_run` toggling; cleared only by `i_reset`.
- Running with `i_atspeed`=1, drop `i_run` → GAP 2 cycles, then BRAKE. Keep `i_atspeed`=1 for 30 cycles, then 0 → IDLE 16 cycles later, `o_busy`=0.
- Drop `i_run` during the first GAP cycle after IDLE → BRAKE after the remaining gap; LOW never driven.
- In HIGH after ready, pulse `i_atspeed` low for 50 cycles → `o_ready` drops then recovers, no fault. A 100-cycle low pulse → FAULT.
